// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and helpers for seven-segment display blocks
// Contents:
//   SEG_BLANK - all segments off (active-low encoding)
//   GLYPHS    - hex glyph table, index n holds the {g,f,e,d,c,b,a} pattern for nibble n
//   clog2()   - ceiling log2 for sizing counters and indices
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Packed so GLYPHS[n] selects the glyph for nibble n (entry 15 is leftmost).
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational nibble to active-low seven-segment decoder
// Ports:
//   nib_i  in  4  hex value to display
//   seg_o  out 7  segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPHS[nib_i];

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed hex display scanner with masking, blanking and frame-synchronous update
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   din      in  4*DIGITS  packed nibbles, digit k = din[4k+3:4k]
//   load     in  1         capture din into staging
//   digit_en in  DIGITS    per-digit enable, 0 = skipped and dark
//   blank_lz in  1         blank leading-zero digits
//   an       out DIGITS    active-low digit select
//   seg      out 7         active-low segments {g,f,e,d,c,b,a}
//   frame    out 1         one-cycle pulse at each frame start
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  load,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame
);

  localparam int IW = clog2(DIGITS);
  localparam int CW = clog2(SCAN_DIV);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] staging_q, staging_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                frame_q, frame_d;

  logic                tick;
  logic                found;
  logic [IW-1:0]       nxt_idx;
  logic [IW-1:0]       cand;
  logic                frame_start;
  logic [DIGITS-1:0]   lz_blank;
  logic                zero_acc;
  logic [3:0]          cur_nib;
  logic [6:0]          glyph;
  logic                lit;
  logic                blank;

  assign tick = (cnt_q == CW'(SCAN_DIV - 1));

  // Cyclic search for the next enabled digit above idx; offset DIGITS lands
  // back on idx itself, so a lone enabled digit keeps its slot.
  always_comb begin
    nxt_idx = idx_q;
    found   = 1'b0;
    cand    = '0;
    for (int off = 1; off <= DIGITS; off++) begin
      cand = IW'((int'(idx_q) + off) % DIGITS);
      if (!found && digit_en[cand]) begin
        found   = 1'b1;
        nxt_idx = cand;
      end
    end
  end

  // A non-increasing step means the scan wrapped (or stayed on one digit).
  assign frame_start = tick && found && (nxt_idx <= idx_q);

  // Digit k is blank when it and every nibble above it are zero; digit 0 always shows.
  always_comb begin
    zero_acc = 1'b1;
    lz_blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_acc    = zero_acc && (shadow_q[4*k +: 4] == 4'h0);
      lz_blank[k] = zero_acc;
    end
    lz_blank[0] = 1'b0;
  end

  always_comb begin
    cur_nib = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) cur_nib = shadow_q[4*k +: 4];
    end
  end

  hex_to_seg u_dec (
    .nib_i (cur_nib),
    .seg_o (glyph)
  );

  assign lit   = digit_en[idx_q];
  assign blank = blank_lz && lz_blank[idx_q];

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    idx_d     = tick ? nxt_idx : idx_q;
    staging_d = load ? din : staging_q;
    // Shadow only takes what was staged before this cycle, so a load on the
    // frame_start cycle waits for the following frame.
    shadow_d  = (frame_start && pending_q) ? staging_q : shadow_q;
    pending_d = load ? 1'b1 : (frame_start ? 1'b0 : pending_q);
    an_d      = lit ? ~(DIGITS'(1) << idx_q) : '1;
    seg_d     = (lit && !blank) ? glyph : SEG_BLANK;
    frame_d   = frame_start;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      staging_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      frame_q   <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed self-checking bench for seg_scan_mux
module tb_seg_scan_mux;

  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] din = '0;
  logic        load = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg_scan_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .din      (din),
    .load     (load),
    .digit_en (digit_en),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .frame    (frame)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [31:0] shv, input int d);
    if (blank_lz && d > 0 && (shv >> (4*d)) == 32'd0) return 7'h7F;
    return GLY[shv[4*d +: 4]];
  endfunction

  // One full frame with all digits enabled, starting on the cycle after a
  // frame start (or reset release); optional loads before steps la and lb.
  task automatic frame_all(input string tag, input logic [31:0] shv,
                           input int la, input logic [31:0] lav,
                           input int lb, input logic [31:0] lbv);
    for (int s = 0; s < 32; s++) begin
      int d;
      logic [7:0] ea;
      logic fb;
      if (s == la) begin din = lav; load = 1'b1; end
      if (s == lb) begin din = lbv; load = 1'b1; end
      step();
      load = 1'b0;
      d  = s / 4;
      ea = ~(8'h01 << d);
      fb = (s == 31);
      chk({tag, "_an"}, an, ea);
      chk({tag, "_seg"}, seg, exp_seg(shv, d));
      chk({tag, "_frame"}, frame, fb);
    end
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) step();
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_frame", frame, 1'b0);

    rstn = 1'b1;
    frame_all("boot", 32'h0, 0, 32'h76543210, -1, 0);
    frame_all("scan", 32'h76543210, -1, 0, -1, 0);

    frame_all("ld1", 32'h76543210, 0, 32'h11111111, -1, 0);
    frame_all("tf1", 32'h11111111, 10, 32'h22222222, -1, 0);
    frame_all("tf2", 32'h22222222, -1, 0, -1, 0);

    frame_all("fs0a", 32'h22222222, 31, 32'h33333333, -1, 0);
    frame_all("fs0b", 32'h22222222, -1, 0, -1, 0);
    frame_all("fs1a", 32'h33333333, 5, 32'h44444444, 31, 32'h55555555);
    frame_all("fs1b", 32'h44444444, -1, 0, -1, 0);
    frame_all("fs1c", 32'h55555555, -1, 0, -1, 0);

    digit_en = 8'b0010_0101;
    for (int s = 0; s < 24; s++) begin
      int slot;
      int d;
      logic [7:0] ea;
      logic fb;
      step();
      slot = (s % 12) / 4;
      d  = (slot == 0) ? 0 : ((slot == 1) ? 2 : 5);
      ea = ~(8'h01 << d);
      fb = ((s % 12) == 11);
      chk("mask_an", an, ea);
      chk("mask_seg", seg, 7'h12);
      chk("mask_frame", frame, fb);
    end

    digit_en = 8'h00;
    for (int s = 0; s < 20; s++) begin
      step();
      chk("off_an", an, 8'hFF);
      chk("off_seg", seg, 7'h7F);
      chk("off_frame", frame, 1'b0);
    end

    digit_en = 8'hFF;
    frame_all("ldb", 32'h55555555, 0, 32'h00000305, -1, 0);
    blank_lz = 1'b1;
    frame_all("blz", 32'h00000305, 0, 32'h0, -1, 0);
    frame_all("blz0", 32'h0, -1, 0, -1, 0);
    blank_lz = 1'b0;
    frame_all("nolz", 32'h0, -1, 0, -1, 0);

    din = 32'h99999999;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (5) step();
    rstn = 1'b0;
    step();
    chk("mrst_an", an, 8'hFF);
    chk("mrst_seg", seg, 7'h7F);
    chk("mrst_frame", frame, 1'b0);
    rstn = 1'b1;
    frame_all("rel", 32'h0, -1, 0, -1, 0);
    frame_all("lost", 32'h0, -1, 0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
